reg_bank_reader: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 10 +
 rtl/reg_bank_word_mux.sv | 10 +
 rtl/reg_bank_reader.sv | 104 ++++++++++
 tb/tb_reg_bank_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared sizes, address/count/word types and reader FSM states for the register bank.
package reg_bank_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   count_t;
    typedef enum logic [1:0] {IDLE, SEND, DONE} rd_state_t;
endpackage

// File: rtl/reg_bank_word_mux.sv
// reg_bank_word_mux: combinational NUM_REGS:1 selection of one word from the flattened bank outputs.
module reg_bank_word_mux
    import reg_bank_pkg::*;
(
    input  logic [NUM_REGS*DATA_W-1:0] bank_data,
    input  logic [ADDR_W-1:0]          addr,
    output logic [DATA_W-1:0]          word
);
    assign word = bank_data[int'(addr)*DATA_W +: DATA_W];
endmodule

// File: rtl/reg_bank_reader.sv
// reg_bank_reader: streams a wrapping window of bank registers over valid/ready with address and last tags.
// REG_BANK_READER_SNAPSHOT_EN: emit words from a copy of the whole bank taken at the accepted start.
module reg_bank_reader
    import reg_bank_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REGS*DATA_W-1:0] bank_data,
    input  logic                       rd_start,
    input  logic [ADDR_W-1:0]          rd_first,
    input  logic [ADDR_W:0]            rd_count,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);
    rd_state_t state_q, state_d;
    addr_t     addr_q, addr_d, sel_addr;
    count_t    rem_q, rem_d;
    word_t     data_q, data_d, word;
    logic      last_q, last_d, valid_q, valid_d, done_q, done_d, busy_q, busy_d;
    logic      start_ok, hs;
    logic [NUM_REGS*DATA_W-1:0] src;

    assign start_ok = state_q == IDLE && rd_start;
    assign hs       = state_q == SEND && valid_q && out_ready;
    assign sel_addr = state_q == IDLE ? rd_first : addr_q + addr_t'(1);

`ifdef REG_BANK_READER_SNAPSHOT_EN
    logic [NUM_REGS*DATA_W-1:0] snap_q, snap_d;
    // The first word is loaded on the same edge the snapshot is taken, so it comes straight from the bank.
    assign snap_d = start_ok ? bank_data : snap_q;
    assign src    = state_q == IDLE ? bank_data : snap_q;
    always_ff @(posedge clk) snap_q <= reset ? '0 : snap_d;
`else
    assign src = bank_data;
`endif

    reg_bank_word_mux u_mux (.bank_data(src), .addr(sel_addr), .word(word));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (start_ok && rd_count != '0) begin
            state_d = SEND;
            addr_d  = rd_first;
            rem_d   = rd_count;
            data_d  = word;
            last_d  = rd_count == count_t'(1);
            valid_d = 1'b1;
        end else if (start_ok) begin
            state_d = DONE;
        end else if (hs && last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (hs) begin
            addr_d = sel_addr;
            data_d = word;
            rem_d  = rem_q - count_t'(1);
            last_d = rem_q == count_t'(2);
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        done_d = state_d == DONE;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_reg_bank_reader.sv
// tb_reg_bank_reader: directed scenario tests for reg_bank_reader with hand-computed expectations.
module tb_reg_bank_reader;
    logic        clk = 1'b0, reset = 1'b1, rd_start = 1'b0, out_ready = 1'b0;
    logic [3:0]  rd_first = '0;
    logic [4:0]  rd_count = '0;
    logic [31:0] bank [16];
    logic [511:0] bank_data;
    logic        out_valid, out_last, busy, done;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;
    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign bank_data[g*32 +: 32] = bank[g];
    end

    reg_bank_reader dut (
        .clk(clk), .reset(reset), .bank_data(bank_data), .rd_start(rd_start),
        .rd_first(rd_first), .rd_count(rd_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] f, input logic [4:0] c);
        rd_first = f;
        rd_count = c;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0 || out_data !== 32'h0 || out_addr !== 4'h0) begin
            n_fail++;
            $display("FAIL reset: valid=%b last=%b busy=%b done=%b data=%h addr=%0d, want all 0",
                     out_valid, out_last, busy, done, out_data, out_addr);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_full_dump();
        out_ready = 1'b1;
        start(4'd0, 5'd16);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== 4'(i) || out_data !== 32'hA000_0000 + i ||
                out_last !== (i == 15) || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL full_dump[%0d]: valid=%b addr=%0d data=%h last=%b done=%b, want 1 %0d %h %b 0",
                         i, out_valid, out_addr, out_data, out_last, done, i, 32'hA000_0000 + i, i == 15);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL full_dump_done: done=%b valid=%b busy=%b last=%b, want 1 0 1 0", done, out_valid, busy, out_last);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_dump_idle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] a;
        out_ready = 1'b1;
        start(4'd14, 5'd4);
        for (int i = 0; i < 4; i++) begin
            a = 4'(14 + i);
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== a || out_data !== bank[a] || out_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: valid=%b addr=%0d data=%h last=%b, want 1 %0d %h %b",
                         i, out_valid, out_addr, out_data, out_last, a, bank[a], i == 3);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b valid=%b, want 1 0", done, out_valid);
        end
        step();
    endtask

    task automatic test_backpressure();
        int hs = 0;
        logic [3:0] a = 4'd2;
        bank[2] = 32'h0000_FFFF;
        bank[3] = 32'h3333_0003;
        bank[4] = 32'h4444_0004;
        out_ready = 1'b0;
        start(4'd2, 5'd3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== 4'd2 || out_data !== 32'h0000_FFFF || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: valid=%b addr=%0d data=%h last=%b, want 1 2 0000ffff 0",
                         k, out_valid, out_addr, out_data, out_last);
            end
            step();
        end
        for (int c = 0; c < 20 && !done; c++) begin
            out_ready = (c % 2) == 0;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_addr !== a || out_data !== bank[a] || out_last !== (hs == 2)) begin
                    n_fail++;
                    $display("FAIL bp_word[%0d]: addr=%0d data=%h last=%b, want %0d %h %b",
                             hs, out_addr, out_data, out_last, a, bank[a], hs == 2);
                end
                hs++;
                a++;
            end
            step();
        end
        n_checks++;
        if (hs != 3 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_count: handshakes=%0d done=%b, want 3 1", hs, done);
        end
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_zero_and_ignore();
        start(4'd6, 5'd0);
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: done=%b valid=%b busy=%b, want 1 0 1", done, out_valid, busy);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: done=%b busy=%b valid=%b, want 0 0 0", done, busy, out_valid);
        end
        out_ready = 1'b0;
        start(4'd0, 5'd3);
        rd_first = 4'd9;
        rd_count = 5'd5;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== 4'(i) || out_data !== bank[i] || out_last !== (i == 2)) begin
                n_fail++;
                $display("FAIL ignore[%0d]: valid=%b addr=%0d data=%h last=%b, want 1 %0d %h %b",
                         i, out_valid, out_addr, out_data, out_last, i, bank[i], i == 2);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_done: done=%b, want 1", done);
        end
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_after: busy=%b valid=%b done=%b, want 0 0 0", busy, out_valid, done);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        start(4'd0, 5'd8);
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 4'd2) begin
            n_fail++;
            $display("FAIL mid_pre: valid=%b addr=%0d, want 1 2", out_valid, out_addr);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0 || out_data !== 32'h0 || out_addr !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b last=%b busy=%b done=%b data=%h addr=%0d, want all 0",
                     out_valid, out_last, busy, done, out_data, out_addr);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_done[%0d]: done=%b busy=%b, want 0 0", k, done, busy);
            end
        end
        start(4'd3, 5'd2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== 4'(3 + i) || out_data !== bank[3 + i] || out_last !== (i == 1)) begin
                n_fail++;
                $display("FAIL mid_fresh[%0d]: valid=%b addr=%0d data=%h last=%b, want 1 %0d %h %b",
                         i, out_valid, out_addr, out_data, out_last, 3 + i, bank[3 + i], i == 1);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fresh_done: done=%b, want 1", done);
        end
        step();
    endtask

    task automatic test_coherency();
        logic [3:0]  a;
        logic [31:0] exp;
`ifdef REG_BANK_READER_SNAPSHOT_EN
        logic [31:0] want7 = 32'hA000_0007;
`else
        logic [31:0] want7 = 32'hDEAD_BEEF;
`endif
        for (int i = 5; i < 9; i++) bank[i] = 32'hA000_0000 + i;
        out_ready = 1'b0;
        start(4'd5, 5'd4);
        bank[7] = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 4'(5 + i);
            exp = (a == 4'd7) ? want7 : 32'hA000_0000 + 32'(a);
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== a || out_data !== exp || out_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL coherency[%0d]: valid=%b addr=%0d data=%h last=%b, want 1 %0d %h %b",
                         i, out_valid, out_addr, out_data, out_last, a, exp, i == 3);
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL coherency_done: done=%b, want 1", done);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 32'hA000_0000 + i;
        test_reset();
        test_full_dump();
        test_wrap();
        test_backpressure();
        test_zero_and_ignore();
        test_mid_reset();
        test_coherency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
